frame_rect_fill: RTL and testbench

FRAME_RECT_FILL -- requirements
Module: frame_rect_fill

---
 rtl/frame_rect_fill.sv | 129 ++++++++++++
 tb/tb_frame_rect_fill.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/frame_rect_fill.sv
// rtl/frame_rect_fill.sv - rectangle fill engine writing a frame buffer in raster order
// Define FRAME_RECT_FILL_CLIP_EN to clip off-screen pixels instead of rejecting the request.
module frame_rect_fill #(
    parameter int H_RES = 320,
    parameter int V_RES = 240
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [8:0]  req_x,
    input  logic [7:0]  req_y,
    input  logic [8:0]  req_w,
    input  logic [7:0]  req_h,
    input  logic [11:0] req_color,
    output logic        wea,
    output logic [16:0] addra,
    output logic [11:0] dina,
    output logic        busy,
    output logic        done,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    localparam logic [9:0]  H_LIM    = 10'(H_RES);
    localparam logic [8:0]  V_LIM    = 9'(V_RES);
    localparam logic [18:0] ROW_STEP = 19'(H_RES);

    state_t      state_q, state_d;
    logic [9:0]  x_q, x_d, col_q, col_d, col_last_q, col_last_d;
    logic [8:0]  row_q, row_d, row_last_q, row_last_d;
    logic [18:0] row_base_q, row_base_d;
    logic [11:0] color_q, color_d;
    logic        err_q, err_d;
    logic        reject, in_range;
    logic [9:0]  x_end;
    logic [8:0]  y_end;

    assign x_end = {1'b0, req_x} + {1'b0, req_w};
    assign y_end = {1'b0, req_y} + {1'b0, req_h};

`ifdef FRAME_RECT_FILL_CLIP_EN
    assign reject   = 1'b0;
    assign in_range = (col_q < H_LIM) && (row_q < V_LIM);
`else
    assign reject   = (x_end > H_LIM) || (y_end > V_LIM) ||
                      ({1'b0, req_x} >= H_LIM) || ({1'b0, req_y} >= V_LIM);
    assign in_range = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        col_d      = col_q;
        col_last_d = col_last_q;
        row_d      = row_q;
        row_last_d = row_last_q;
        row_base_d = row_base_q;
        color_d    = color_q;
        err_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    x_d        = {1'b0, req_x};
                    col_d      = {1'b0, req_x};
                    col_last_d = x_end - 10'd1;
                    row_d      = {1'b0, req_y};
                    row_last_d = y_end - 9'd1;
                    // One multiply per request; the per-pixel path only adds ROW_STEP.
                    row_base_d = 19'(req_y) * ROW_STEP;
                    color_d    = req_color;
                    if (reject)
                        err_d = 1'b1;
                    else if (req_w == 9'd0 || req_h == 8'd0)
                        state_d = DONE;
                    else
                        state_d = FILL;
                end
            end
            FILL: begin
                if (col_q == col_last_q) begin
                    col_d = x_q;
                    if (row_q == row_last_q) begin
                        state_d = DONE;
                    end else begin
                        row_d      = row_q + 9'd1;
                        row_base_d = row_base_q + ROW_STEP;
                    end
                end else begin
                    col_d = col_q + 10'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            x_q        <= '0;
            col_q      <= '0;
            col_last_q <= '0;
            row_q      <= '0;
            row_last_q <= '0;
            row_base_q <= '0;
            color_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            col_q      <= col_d;
            col_last_q <= col_last_d;
            row_q      <= row_d;
            row_last_q <= row_last_d;
            row_base_q <= row_base_d;
            color_q    <= color_d;
            err_q      <= err_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign wea       = (state_q == FILL) && in_range;
    assign addra     = 17'(row_base_q + 19'(col_q));
    assign dina      = color_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign err       = err_q;
endmodule

// File: tb/tb_frame_rect_fill.sv
// tb/tb_frame_rect_fill.sv - directed table-driven bench for frame_rect_fill
module tb_frame_rect_fill;
    localparam int H = 320;
    localparam int V = 240;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [8:0]  req_x = '0;
    logic [7:0]  req_y = '0;
    logic [8:0]  req_w = '0;
    logic [7:0]  req_h = '0;
    logic [11:0] req_color = '0;
    logic        wea;
    logic [16:0] addra;
    logic [11:0] dina;
    logic        busy, done, err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    frame_rect_fill dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_w(req_w), .req_h(req_h), .req_color(req_color),
        .wea(wea), .addra(addra), .dina(dina), .busy(busy), .done(done), .err(err)
    );

    typedef struct {
        int x; int y; int w; int h; int color;
        int exp_writes; int exp_first; int exp_last; int exp_done_cyc; int exp_err_cyc;
    } vec_t;

    vec_t vecs[9];

    function automatic vec_t mk(int x, int y, int w, int h, int color,
                                int wr, int first, int last, int dc, int ec);
        vec_t v;
        v.x = x; v.y = y; v.w = w; v.h = h; v.color = color;
        v.exp_writes = wr; v.exp_first = first; v.exp_last = last;
        v.exp_done_cyc = dc; v.exp_err_cyc = ec;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic issue(input int x, input int y, input int w, input int h, input int color,
                         input string name);
        int c;
        @(negedge clk);
        req_x = 9'(x); req_y = 8'(y); req_w = 9'(w); req_h = 8'(h); req_color = 12'(color);
        req_valid = 1'b1;
        c = 0;
        while (!req_ready && c < 100) begin
            @(negedge clk);
            c++;
        end
        if (c >= 100) check({name, " ready_wait"}, 0, 1);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int c, k, nwr, first_a, last_a, done_cyc, err_cyc, seq_bad, busy_bad, row, col, limit;
        bit exp_we;
        issue(v.x, v.y, v.w, v.h, v.color, name);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_x = 9'h1FF; req_y = 8'hFF; req_w = 9'h1FF; req_h = 8'hFF; req_color = 12'hBAD;
        nwr = 0; first_a = -1; last_a = -1; done_cyc = 0; err_cyc = 0;
        seq_bad = 0; busy_bad = 0; k = 0; c = 0;
        limit = v.w * v.h + 20;
        while (done_cyc == 0 && err_cyc == 0 && c < limit) begin
            @(negedge clk);
            c++;
            if (wea) begin
                nwr++;
                if (first_a < 0) first_a = int'(addra);
                last_a = int'(addra);
                if (int'(dina) != v.color) seq_bad++;
            end
            if (!busy && !err) busy_bad++;
            if (done) done_cyc = c;
            if (err) err_cyc = c;
            if (!done && !err) begin
                if (k < v.w * v.h) begin
                    row = v.y + k / v.w;
                    col = v.x + k % v.w;
                    exp_we = (row < V) && (col < H);
                    if (wea != exp_we || (exp_we && int'(addra) != row * H + col)) begin
                        if (seq_bad == 0)
                            $display("FAIL %s pixel %0d: wea=%0b addra=%0d expected wea=%0b addra=%0d",
                                     name, k, wea, addra, exp_we, row * H + col);
                        seq_bad++;
                    end
                    k++;
                end else begin
                    seq_bad++;
                end
            end
        end
        check({name, " writes"}, nwr, v.exp_writes);
        if (v.exp_writes > 0) begin
            check({name, " first_addr"}, first_a, v.exp_first);
            check({name, " last_addr"}, last_a, v.exp_last);
        end
        check({name, " seq_errors"}, seq_bad, 0);
        check({name, " busy_gaps"}, busy_bad, 0);
        check({name, " done_cycle"}, done_cyc, v.exp_done_cyc);
        check({name, " err_cycle"}, err_cyc, v.exp_err_cyc);
        @(negedge clk);
        check({name, " idle_after"}, {req_ready, busy, wea, done, err}, 5'b10000);
    endtask

    task automatic reset_mid_fill();
        int c, nwr;
        issue(2, 3, 5, 5, 12'hABC, "rst_mid");
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        c = 0; nwr = 0;
        while (nwr < 10 && c < 30) begin
            @(negedge clk);
            c++;
            if (wea) nwr++;
        end
        check("rst_mid tenth_write_seen", nwr, 10);
        check("rst_mid tenth_addr", int'(addra), 4 * H + 6);
        #2 rst = 1'b0;
        #1;
        check("rst_mid async_flags", {req_ready, wea, busy, done, err}, 5'b10000);
        check("rst_mid async_addra", int'(addra), 0);
        check("rst_mid async_dina", int'(dina), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        nwr = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (wea || done || err || busy) nwr++;
        end
        check("rst_mid quiet_after_release", nwr, 0);
    endtask

    task automatic back_to_back();
        int exp_a[12];
        bit [2:0] exp_f[12];
        exp_a = '{0, 1610, 1611, 1612, 1930, 1931, 1932, 0, 0, 320, 321, 0};
        // {wea, done, req_ready} per cycle after the first accept
        exp_f = '{3'b000, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100,
                  3'b010, 3'b001, 3'b100, 3'b100, 3'b010};
        issue(10, 5, 3, 2, 12'hF00, "b2b");
        @(posedge clk);
        #1;
        req_x = 9'd0; req_y = 8'd1; req_w = 9'd2; req_h = 8'd1; req_color = 12'h00F;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            check($sformatf("b2b flags c%0d", c), {wea, done, req_ready}, exp_f[c]);
            if (exp_f[c][2]) check($sformatf("b2b addr c%0d", c), int'(addra), exp_a[c]);
            if (c == 9) begin
                check("b2b second_color", int'(dina), 12'h00F);
                req_valid = 1'b0;
            end
        end
    endtask

    initial begin
        vecs[0] = mk(10, 5, 3, 2, 12'hF00, 6, 1610, 1932, 7, 0);
        vecs[1] = mk(0, 0, 0, 7, 12'h555, 0, 0, 0, 1, 0);
`ifdef FRAME_RECT_FILL_CLIP_EN
        vecs[2] = mk(318, 239, 4, 2, 12'h0FF, 2, 76798, 76799, 9, 0);
`else
        vecs[2] = mk(318, 239, 4, 2, 12'h0FF, 0, 0, 0, 0, 1);
`endif
        vecs[3] = mk(319, 239, 1, 1, 12'h0AB, 1, 76799, 76799, 2, 0);
        vecs[4] = mk(0, 0, 320, 240, 12'h0F0, 76800, 0, 76799, 76801, 0);
`ifdef FRAME_RECT_FILL_CLIP_EN
        vecs[5] = mk(300, 0, 21, 1, 12'h321, 20, 300, 319, 22, 0);
`else
        vecs[5] = mk(300, 0, 21, 1, 12'h321, 0, 0, 0, 0, 1);
`endif
        vecs[6] = mk(5, 100, 1, 3, 12'h123, 3, 32005, 32645, 4, 0);
        vecs[7] = mk(0, 0, 5, 0, 12'h777, 0, 0, 0, 1, 0);
`ifdef FRAME_RECT_FILL_CLIP_EN
        vecs[8] = mk(320, 0, 1, 1, 12'h888, 0, 0, 0, 2, 0);
`else
        vecs[8] = mk(320, 0, 1, 1, 12'h888, 0, 0, 0, 0, 1);
`endif

        #3;
        check("reset flags", {req_ready, wea, busy, done, err}, 5'b10000);
        check("reset addra", int'(addra), 0);
        check("reset dina", int'(dina), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        reset_mid_fill();
        run_vec(vecs[0], "post_reset_vec0");
        back_to_back();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
